// File: rtl/lsu_pkg.sv
// Shared types, constants and lane helpers for the load/store stage and its store buffer.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  localparam logic [6:0] ECODE_ALE = 7'h09;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_CHECK = 3'd1,
    LD_REQ   = 3'd2,
    LD_WAIT  = 3'd3,
    LD_DONE  = 3'd4
  } ld_state_e;

  // Byte strobes for an access of the given size starting at byte lane 'lane'.
  function automatic logic [7:0] strb_gen(input lsu_size_e size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  // Moves the addressed lane down to bit 0 and sign- or zero-extends it.
  function automatic logic [63:0] load_extract(input logic [63:0] data, input lsu_size_e size,
                                               input logic [2:0] lane, input logic is_unsigned);
    logic [63:0] sh;
    logic [63:0] res;
    sh = data >> {lane, 3'b000};
    case (size)
      SZ_B:    res = is_unsigned ? {56'b0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      SZ_H:    res = is_unsigned ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_W:    res = is_unsigned ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_store_buffer.sv
// In-order store buffer: circular FIFO of committed stores with a word-address hit
// query across all valid entries, used to hold back overlapping loads.
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [ADDR_W-1:0]          push_addr_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic [DATA_W/8-1:0]        push_strb_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [ADDR_W-1:0]          head_addr_o,
  output logic [DATA_W-1:0]          head_data_o,
  output logic [DATA_W/8-1:0]        head_strb_o,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0] query_waddr_i,
  output logic                       hit_o
);

  localparam int OFF_W  = $clog2(DATA_W/8);
  localparam int WA_W   = ADDR_W - OFF_W;
  localparam int STRB_W = DATA_W/8;
  localparam int PTR_W  = $clog2(DEPTH);

  logic [WA_W-1:0]   waddr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [STRB_W-1:0] strb_mem  [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [DEPTH-1:0] hit_vec;

  assign empty_o = ~|valid_q;
  assign full_o  = &valid_q;

  // When full, a simultaneous pop and push target the same slot; the set must win.
  always_comb begin
    valid_d = valid_q;
    if (pop_i)  valid_d[head_q] = 1'b0;
    if (push_i) valid_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (pop_i)  head_q <= head_q + 1'b1;
      if (push_i) tail_q <= tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      waddr_mem[tail_q] <= push_addr_i[ADDR_W-1:OFF_W];
      data_mem[tail_q]  <= push_data_i;
      strb_mem[tail_q]  <= push_strb_i;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign hit_vec[gi] = valid_q[gi] && (waddr_mem[gi] == query_waddr_i);
  end
  assign hit_o = |hit_vec;

  assign head_addr_o = empty_o ? '0 : {waddr_mem[head_q], {OFF_W{1'b0}}};
  assign head_data_o = empty_o ? '0 : data_mem[head_q];
  assign head_strb_o = empty_o ? '0 : strb_mem[head_q];

endmodule

// File: rtl/lsu_sb_stage.sv
// EX->WB load/store stage: alignment check, store formatting into an in-order store
// buffer, and a load FSM that waits out overlapping buffered stores before reading.
module lsu_sb_stage
  import lsu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_load,
  input  logic                in_store,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_excp,
  output logic [6:0]          out_ecode,
  output logic                rd_req_valid,
  input  logic                rd_req_ready,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_resp_valid,
  input  logic [DATA_W-1:0]   rd_resp_data,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  output logic                sb_empty
);

  localparam int OFF_W  = $clog2(DATA_W/8);
  localparam int STRB_W = DATA_W/8;

  ld_state_e         state_q, state_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_excp_q, res_excp_d;
  logic              drop_pending_q, drop_pending_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  lsu_size_e         ld_size_q, ld_size_d;
  logic              ld_uns_q, ld_uns_d;

  logic              sb_full, sb_hit, sb_push, sb_pop, sb_can_push;
  logic [2:0]        in_lane, ld_lane, size_mask;
  logic              misal, accept;
  logic [DATA_W-1:0] st_data;
  logic [STRB_W-1:0] st_strb;

  always_comb begin
    case (in_size)
      2'd0:    size_mask = 3'b000;
      2'd1:    size_mask = 3'b001;
      2'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  end

  assign in_lane = 3'(in_addr[OFF_W-1:0]);
  assign ld_lane = 3'(ld_addr_q[OFF_W-1:0]);
  assign misal   = (in_load || in_store) &&
                   (((in_addr[2:0] & size_mask) != 3'b000) || ((in_size == 2'd3) && (DATA_W == 32)));

  assign sb_pop      = wr_valid && wr_ready;
  assign sb_can_push = !sb_full || sb_pop;
  assign in_ready    = (state_q == LD_IDLE) && !drop_pending_q && (!res_valid_q || out_ready) &&
                       (!in_store || sb_can_push);
  assign accept      = in_valid && in_ready && !flush;
  assign sb_push     = accept && in_store && !misal;

  assign st_data = in_wdata << {in_lane, 3'b000};
  assign st_strb = STRB_W'(strb_gen(lsu_size_e'(in_size), in_lane));

  lsu_store_buffer #(
    .DEPTH  (SB_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .push_i        (sb_push),
    .push_addr_i   (in_addr),
    .push_data_i   (st_data),
    .push_strb_i   (st_strb),
    .pop_i         (sb_pop),
    .full_o        (sb_full),
    .empty_o       (sb_empty),
    .head_addr_o   (wr_addr),
    .head_data_o   (wr_data),
    .head_strb_o   (wr_strb),
    .query_waddr_i (ld_addr_q[ADDR_W-1:OFF_W]),
    .hit_o         (sb_hit)
  );

  assign wr_valid  = !sb_empty;
  assign rd_addr   = {ld_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign out_valid = res_valid_q;
  assign out_data  = res_data_q;
  assign out_excp  = res_excp_q;
  assign out_ecode = res_excp_q ? ECODE_ALE : 7'h00;

  always_comb begin
    state_d        = state_q;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_excp_d     = res_excp_q;
    drop_pending_d = drop_pending_q;
    ld_addr_d      = ld_addr_q;
    ld_size_d      = ld_size_q;
    ld_uns_d       = ld_uns_q;
    rd_req_valid   = 1'b0;

    if (drop_pending_q && rd_resp_valid) drop_pending_d = 1'b0;
    if (res_valid_q && out_ready)        res_valid_d    = 1'b0;

    unique case (state_q)
      LD_IDLE: begin
        if (accept) begin
          if (misal) begin
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_excp_d  = 1'b1;
          end else if (in_store || !in_load) begin
            res_valid_d = 1'b1;
            res_data_d  = DATA_W'(in_addr);
            res_excp_d  = 1'b0;
          end else begin
            state_d   = LD_CHECK;
            ld_addr_d = in_addr;
            ld_size_d = lsu_size_e'(in_size);
            ld_uns_d  = in_unsigned;
          end
        end
      end
      // The request goes out straight from CHECK once no older store overlaps.
      LD_CHECK: begin
        if (!sb_hit) begin
          rd_req_valid = 1'b1;
          state_d      = rd_req_ready ? LD_WAIT : LD_REQ;
        end
      end
      LD_REQ: begin
        rd_req_valid = 1'b1;
        if (rd_req_ready) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        if (rd_resp_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = DATA_W'(load_extract(64'(rd_resp_data), ld_size_q, ld_lane, ld_uns_q));
          res_excp_d  = 1'b0;
          state_d     = LD_DONE;
        end
      end
      LD_DONE: begin
        if (out_ready) state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase

    // A read already accepted by memory still owes a response; swallow it later.
    if (flush) begin
      if ((rd_req_valid && rd_req_ready) || (state_q == LD_WAIT && !rd_resp_valid))
        drop_pending_d = 1'b1;
      state_d     = LD_IDLE;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LD_IDLE;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_excp_q     <= 1'b0;
      drop_pending_q <= 1'b0;
      ld_addr_q      <= '0;
      ld_size_q      <= SZ_B;
      ld_uns_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_excp_q     <= res_excp_d;
      drop_pending_q <= drop_pending_d;
      ld_addr_q      <= ld_addr_d;
      ld_size_q      <= ld_size_d;
      ld_uns_q       <= ld_uns_d;
    end
  end

endmodule

// File: tb/tb_lsu_sb_stage.sv
// Directed bench for lsu_sb_stage: a 32-bit/4-entry instance and a 64-bit/2-entry instance.
module tb_lsu_sb_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---- 32-bit instance signals
  logic        a_flush, a_in_valid, a_in_ready, a_in_load, a_in_store, a_in_unsigned;
  logic [1:0]  a_in_size;
  logic [31:0] a_in_addr, a_in_wdata;
  logic        a_out_valid, a_out_ready, a_out_excp;
  logic [31:0] a_out_data;
  logic [6:0]  a_out_ecode;
  logic        a_rd_req_valid, a_rd_req_ready, a_rd_resp_valid;
  logic [31:0] a_rd_addr, a_rd_resp_data;
  logic        a_wr_valid, a_wr_ready, a_sb_empty;
  logic [31:0] a_wr_addr, a_wr_data;
  logic [3:0]  a_wr_strb;

  // ---- 64-bit instance signals
  logic        b_flush, b_in_valid, b_in_ready, b_in_load, b_in_store, b_in_unsigned;
  logic [1:0]  b_in_size;
  logic [31:0] b_in_addr;
  logic [63:0] b_in_wdata;
  logic        b_out_valid, b_out_ready, b_out_excp;
  logic [63:0] b_out_data;
  logic [6:0]  b_out_ecode;
  logic        b_rd_req_valid, b_rd_req_ready, b_rd_resp_valid;
  logic [31:0] b_rd_addr;
  logic [63:0] b_rd_resp_data;
  logic        b_wr_valid, b_wr_ready, b_sb_empty;
  logic [31:0] b_wr_addr;
  logic [63:0] b_wr_data;
  logic [7:0]  b_wr_strb;

  lsu_sb_stage #(.DATA_W(32), .ADDR_W(32), .SB_DEPTH(4)) u_dut32 (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_load(a_in_load), .in_store(a_in_store),
    .in_size(a_in_size), .in_unsigned(a_in_unsigned), .in_addr(a_in_addr), .in_wdata(a_in_wdata),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_excp(a_out_excp), .out_ecode(a_out_ecode),
    .rd_req_valid(a_rd_req_valid), .rd_req_ready(a_rd_req_ready), .rd_addr(a_rd_addr),
    .rd_resp_valid(a_rd_resp_valid), .rd_resp_data(a_rd_resp_data),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_strb(a_wr_strb), .sb_empty(a_sb_empty)
  );

  lsu_sb_stage #(.DATA_W(64), .ADDR_W(32), .SB_DEPTH(2)) u_dut64 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_load(b_in_load), .in_store(b_in_store),
    .in_size(b_in_size), .in_unsigned(b_in_unsigned), .in_addr(b_in_addr), .in_wdata(b_in_wdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_excp(b_out_excp), .out_ecode(b_out_ecode),
    .rd_req_valid(b_rd_req_valid), .rd_req_ready(b_rd_req_ready), .rd_addr(b_rd_addr),
    .rd_resp_valid(b_rd_resp_valid), .rd_resp_data(b_rd_resp_data),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_strb(b_wr_strb), .sb_empty(b_sb_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    a_in_valid = 1'b1; a_in_load = ld; a_in_store = st; a_in_size = sz;
    a_in_unsigned = uns; a_in_addr = addr; a_in_wdata = wd;
    #1;
    chk("a_in_ready_at_issue", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0; a_in_load = 1'b0; a_in_store = 1'b0;
  endtask

  task automatic b_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [63:0] wd);
    b_in_valid = 1'b1; b_in_load = ld; b_in_store = st; b_in_size = sz;
    b_in_unsigned = uns; b_in_addr = addr; b_in_wdata = wd;
    #1;
    chk("b_in_ready_at_issue", b_in_ready, 1);
    tick();
    b_in_valid = 1'b0; b_in_load = 1'b0; b_in_store = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_load = 0; a_in_store = 0; a_in_size = 0; a_in_unsigned = 0;
    a_in_addr = 0; a_in_wdata = 0; a_out_ready = 1; a_rd_req_ready = 1; a_rd_resp_valid = 0;
    a_rd_resp_data = 0; a_wr_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_load = 0; b_in_store = 0; b_in_size = 0; b_in_unsigned = 0;
    b_in_addr = 0; b_in_wdata = 0; b_out_ready = 1; b_rd_req_ready = 1; b_rd_resp_valid = 0;
    b_rd_resp_data = 0; b_wr_ready = 0;
    tick(); tick();

    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_excp", a_out_excp, 0);
    chk("rst_out_ecode", a_out_ecode, 0);
    chk("rst_rd_req_valid", a_rd_req_valid, 0);
    chk("rst_rd_addr", a_rd_addr, 0);
    chk("rst_wr_valid", a_wr_valid, 0);
    chk("rst_wr_addr", a_wr_addr, 0);
    chk("rst_wr_data", a_wr_data, 0);
    chk("rst_wr_strb", a_wr_strb, 0);
    chk("rst_sb_empty", a_sb_empty, 1);
    chk("rst_b_sb_empty", b_sb_empty, 1);
    reset = 1'b0;
    tick();

    // Byte store to 0x1003: lane 3
    a_op(0, 1, 2'd0, 0, 32'h1003, 32'h0000_00A5);
    chk("st_out_valid", a_out_valid, 1);
    chk("st_out_data", a_out_data, 32'h1003);
    chk("st_wr_valid", a_wr_valid, 1);
    chk("st_wr_addr", a_wr_addr, 32'h1000);
    chk("st_wr_strb", a_wr_strb, 4'b1000);
    chk("st_wr_data", a_wr_data, 32'hA500_0000);

    // Fill the 4-entry buffer while wr_ready=0
    a_op(0, 1, 2'd2, 0, 32'h2000, 32'hDEAD_BEEF);
    a_op(0, 1, 2'd1, 0, 32'h3002, 32'h0000_BEEF);
    a_op(0, 1, 2'd0, 0, 32'h4001, 32'h0000_0077);
    a_in_valid = 1; a_in_store = 1; a_in_size = 2'd2; a_in_addr = 32'h7000;
    #1;
    chk("full_store_stall", a_in_ready, 0);
    a_in_valid = 0; a_in_store = 0;

    // Signed byte load to the word held at the buffer head: must wait in CHECK
    a_op(1, 0, 2'd0, 0, 32'h1003, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("conflict_no_req", a_rd_req_valid, 0);
      tick();
    end
    a_wr_ready = 1;
    #1;
    chk("conflict_pop_cycle_no_req", a_rd_req_valid, 0);
    chk("conflict_head_addr", a_wr_addr, 32'h1000);
    tick();
    chk("conflict_released_req", a_rd_req_valid, 1);
    chk("conflict_rd_addr", a_rd_addr, 32'h1000);
    chk("fifo_order_2", a_wr_addr, 32'h2000);
    chk("fifo_strb_2", a_wr_strb, 4'hF);
    a_out_ready = 0;
    tick();
    chk("wait_no_req", a_rd_req_valid, 0);
    chk("fifo_order_3", a_wr_addr, 32'h3000);
    chk("fifo_strb_3", a_wr_strb, 4'b1100);
    chk("fifo_data_3", a_wr_data, 32'hBEEF_0000);
    a_rd_resp_valid = 1; a_rd_resp_data = 32'hA500_0000;
    tick();
    a_rd_resp_valid = 0;
    chk("ld_sb_out_valid", a_out_valid, 1);
    chk("ld_sb_out_data", a_out_data, 32'hFFFF_FFA5);
    chk("ld_sb_out_excp", a_out_excp, 0);

    // Back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_out_data", a_out_data, 32'hFFFF_FFA5);
      chk("bp_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1;
    tick();
    chk("bp_single_transfer", a_out_valid, 0);
    chk("bp_in_ready_back", a_in_ready, 1);
    chk("drained_empty", a_sb_empty, 1);

    // Misaligned ops
    a_op(1, 0, 2'd1, 0, 32'h2001, 32'h0);
    chk("mis_ld_excp", a_out_excp, 1);
    chk("mis_ld_ecode", a_out_ecode, 7'h09);
    chk("mis_ld_data", a_out_data, 0);
    chk("mis_ld_no_req", a_rd_req_valid, 0);
    a_op(0, 1, 2'd1, 0, 32'h2001, 32'h1234);
    chk("mis_st_excp", a_out_excp, 1);
    chk("mis_st_no_wr", a_wr_valid, 0);
    a_op(1, 0, 2'd3, 0, 32'h1000, 32'h0);
    chk("dword32_excp", a_out_excp, 1);
    chk("dword32_ecode", a_out_ecode, 7'h09);
    chk("dword32_no_req", a_rd_req_valid, 0);

    // Pass-through
    a_op(0, 0, 2'd2, 0, 32'h1234_5678, 32'h0);
    chk("pt_out_valid", a_out_valid, 1);
    chk("pt_out_data", a_out_data, 32'h1234_5678);
    chk("pt_out_excp", a_out_excp, 0);
    chk("pt_out_ecode", a_out_ecode, 0);
    chk("pt_no_wr", a_wr_valid, 0);

    // Unsigned half load, best-case latency
    a_op(1, 0, 2'd1, 1, 32'h3002, 32'h0);
    chk("ldh_req_valid", a_rd_req_valid, 1);
    chk("ldh_rd_addr", a_rd_addr, 32'h3000);
    tick();
    chk("ldh_wait_no_out", a_out_valid, 0);
    a_rd_resp_valid = 1; a_rd_resp_data = 32'hBEEF_0000;
    tick();
    a_rd_resp_valid = 0;
    chk("ldh_out_valid", a_out_valid, 1);
    chk("ldh_out_data", a_out_data, 32'h0000_BEEF);
    tick();

    // Flush while a read is outstanding; buffered store must survive
    a_wr_ready = 0;
    a_op(0, 1, 2'd2, 0, 32'h6000, 32'hCAFE_F00D);
    a_op(1, 0, 2'd2, 0, 32'h5000, 32'h0);
    chk("fl_req_valid", a_rd_req_valid, 1);
    tick();
    a_flush = 1;
    tick();
    a_flush = 0;
    chk("fl_drop_in_ready", a_in_ready, 0);
    chk("fl_out_valid", a_out_valid, 0);
    chk("fl_no_req", a_rd_req_valid, 0);
    tick();
    chk("fl_out_valid_2", a_out_valid, 0);
    a_rd_resp_valid = 1; a_rd_resp_data = 32'h1122_3344;
    tick();
    a_rd_resp_valid = 0;
    chk("fl_in_ready_after_resp", a_in_ready, 1);
    chk("fl_resp_dropped", a_out_valid, 0);
    tick();
    chk("fl_resp_dropped_2", a_out_valid, 0);
    chk("fl_store_kept_valid", a_wr_valid, 1);
    chk("fl_store_kept_addr", a_wr_addr, 32'h6000);
    chk("fl_store_kept_data", a_wr_data, 32'hCAFE_F00D);
    a_wr_ready = 1;
    tick();
    chk("fl_store_drained", a_sb_empty, 1);

    // 64-bit instance, 2-entry buffer
    b_op(0, 1, 2'd3, 0, 32'h100, 64'h1122_3344_5566_7788);
    b_op(0, 1, 2'd0, 0, 32'h10B, 64'h5A);
    b_in_valid = 1; b_in_store = 1; b_in_size = 2'd1; b_in_addr = 32'h116; b_in_wdata = 64'h7777;
    #1;
    chk("b_full_stall", b_in_ready, 0);
    tick();
    chk("b_full_stall_2", b_in_ready, 0);
    chk("b_head_addr", b_wr_addr, 32'h100);
    chk("b_head_data", b_wr_data, 64'h1122_3344_5566_7788);
    chk("b_head_strb", b_wr_strb, 8'hFF);
    b_wr_ready = 1;
    #1;
    chk("b_push_pop_ready", b_in_ready, 1);
    tick();
    b_in_valid = 0; b_in_store = 0; b_wr_ready = 0;
    chk("b_third_done", b_out_data, 32'h116);
    chk("b_fifo_addr_2", b_wr_addr, 32'h108);
    chk("b_fifo_strb_2", b_wr_strb, 8'h08);
    chk("b_fifo_data_2", b_wr_data, 64'h0000_0000_5A00_0000);
    b_wr_ready = 1;
    tick();
    chk("b_fifo_addr_3", b_wr_addr, 32'h110);
    chk("b_fifo_strb_3", b_wr_strb, 8'hC0);
    chk("b_fifo_data_3", b_wr_data, 64'h7777_0000_0000_0000);
    tick();
    chk("b_drained", b_sb_empty, 1);

    // Signed word load from the upper lane of a 64-bit beat
    b_op(1, 0, 2'd2, 0, 32'h104, 64'h0);
    chk("b_ld_req", b_rd_req_valid, 1);
    chk("b_ld_rd_addr", b_rd_addr, 32'h100);
    tick();
    b_rd_resp_valid = 1; b_rd_resp_data = 64'h8000_0001_0000_0000;
    tick();
    b_rd_resp_valid = 0;
    chk("b_ld_out_valid", b_out_valid, 1);
    chk("b_ld_out_data", b_out_data, 64'hFFFF_FFFF_8000_0001);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
